// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_tx
// Brief    : Latches a parallel pattern and shifts its active window out MSB
//            first, one bit per clock. Define SERIAL_PATTERN_TX_REPEAT_EN to
//            add the rpt input for gapless frame repetition.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] len,
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    input  logic                       rpt,
`endif
    output logic                       out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int LW = $clog2(WIDTH+1);
    localparam logic [LW-1:0] c_WIDTH = LW'(WIDTH);
    localparam logic [LW-1:0] c_ONE   = LW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [LW-1:0]    r_cnt,   w_cnt_nxt;
    logic             r_out,   w_out_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;

    logic [LW-1:0]    w_len_eff;
    logic [WIDTH-1:0] w_aligned;

    // Out-of-range lengths fall back to the full width; the pattern is then
    // left-aligned so the first bit to send always sits at the MSB.
    assign w_len_eff = ((len == '0) || (len > c_WIDTH)) ? c_WIDTH : len;
    assign w_aligned = pattern << (c_WIDTH - w_len_eff);

`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    logic [WIDTH-1:0] r_pat, w_pat_nxt;
    logic [LW-1:0]    r_len, w_len_nxt;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
            r_pat   <= '0;
            r_len   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
`endif
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_shreg_nxt = w_aligned << 1;
                    w_cnt_nxt   = w_len_eff;
                    w_out_nxt   = w_aligned[WIDTH-1];
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
                    w_pat_nxt   = w_aligned;
                    w_len_nxt   = w_len_eff;
`endif
                end
            end
            SHIFT: begin
                // r_cnt counts bits still to be presented, including the current one
                if (r_cnt == c_ONE) begin
                    w_done_nxt = 1'b1;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
                    if (rpt) begin
                        w_shreg_nxt = r_pat << 1;
                        w_cnt_nxt   = r_len;
                        w_out_nxt   = r_pat[WIDTH-1];
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end
`else
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
`endif
                end else begin
                    w_shreg_nxt = r_shreg << 1;
                    w_cnt_nxt   = r_cnt - c_ONE;
                    w_out_nxt   = r_shreg[WIDTH-1];
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// Scoreboard bench for serial_pattern_tx: the driver predicts the timed bit
// stream per frame, a negedge monitor pops and compares what the DUT presents.
`timescale 1ns/1ps
module tb_serial_pattern_tx;
    localparam int W  = 8;
    localparam int LW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic [LW-1:0] len = '0;
    logic          out, out_valid, busy, done;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    logic          rpt = 1'b0;
`endif

    serial_pattern_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        .rpt       (rpt),
`endif
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int   e;
        logic b;
    } bit_t;

    bit_t     bq[$];
    int       dq[$];
    int       edge_no = 0;
    int       next_ok = 0;
    int       cur_end = -1;
    logic [W-1:0] cur_pat = '0;
    int       cur_l = 0;
    int       total = 0;
    int       bad = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_no);
        end
    endtask

    // Reference: an accepted frame of length L at edge E owns bit slots E..E+L-1
    // and a done pulse in slot E+L; the next start can be taken at edge E+L+1.
    task automatic push_frame(input int e, input logic [W-1:0] pat, input int l);
        for (int k = 0; k < l; k++) bq.push_back(bit_t'{e + k, pat[l-1-k]});
        dq.push_back(e + l);
        cur_end = e + l;
        cur_pat = pat;
        cur_l   = l;
        next_ok = e + l + 1;
    endtask

    task automatic cyc(input bit st, input logic [W-1:0] pat, input int ln, input bit rp);
        int e;
        int l;
        @(negedge clk);
        start   = st;
        pattern = pat;
        len     = ln[LW-1:0];
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        rpt     = rp;
`endif
        e = edge_no + 1;
        l = (ln == 0 || ln > W) ? W : ln;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        if (rp && e == cur_end) push_frame(e, cur_pat, cur_l);
`endif
        if (st && rstn && e >= next_ok) push_frame(e, pat, l);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), $urandom_range(0, 15), 1'b0);
    endtask

    always @(negedge clk) begin
        while (bq.size() > 0 && bq[0].e < edge_no) begin
            chk("bit_missing_at_slot", edge_no, bq[0].e);
            void'(bq.pop_front());
        end
        while (dq.size() > 0 && dq[0] < edge_no) begin
            chk("done_missing_at_slot", edge_no, dq[0]);
            void'(dq.pop_front());
        end
        chk("busy_vs_valid", busy, out_valid);
        if (out_valid) begin
            if (bq.size() == 0) chk("unexpected_valid", out_valid, 0);
            else if (bq[0].e != edge_no) chk("valid_slot", edge_no, bq[0].e);
            else begin
                chk("out_bit", out, bq[0].b);
                void'(bq.pop_front());
            end
        end else begin
            chk("out_zero_when_invalid", out, 0);
        end
        if (done) begin
            if (dq.size() == 0) chk("unexpected_done", done, 0);
            else if (dq[0] != edge_no) chk("done_slot", edge_no, dq[0]);
            else void'(dq.pop_front());
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out", out, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rstn = 1'b1;

        cyc(1'b1, 8'b1011_0010, 8, 1'b0); idle(10);
        cyc(1'b1, 8'h0D, 4, 1'b0);        idle(6);
        cyc(1'b1, 8'hFF, 0, 1'b0);        idle(10);

        cyc(1'b1, 8'hA6, 8, 1'b0); idle(2);
        cyc(1'b1, 8'h00, 8, 1'b0); idle(10);

        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h05, 3, 1'b0);
        idle(5);

        // Abort while bit 3 of an 8-bit frame is on the line.
        cyc(1'b1, 8'hB5, 8, 1'b0); idle(3);
        #2 rstn = 1'b0;
        #1;
        chk("abort_out", out, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        bq.delete();
        dq.delete();
        next_ok = 0;
        cur_end = -1;
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b1, 8'h3C, 8, 1'b0); idle(10);

`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        cyc(1'b1, 8'h06, 3, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 0, 1'b1);
        idle(6);
`endif

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) == 0), W'($urandom), $urandom_range(0, 15),
                ($urandom_range(0, 3) == 0));
        end
        idle(40);

        chk("bits_left", bq.size(), 0);
        chk("dones_left", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
